// File: rtl/sigmoid_gate_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sigmoid_gate_scheduler                                           |
// | Brief   : Round-robin share of one sigmoid unit across gate requesters,    |
// |           two-stage pipeline with tagged results and backpressure.         |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module sigmoid_gate_scheduler #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8,
    parameter int NUM_REQ   = 3,
    parameter int ID_W      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         sig_in,
    input  logic [WIDTH-1:0]         sig_out,
    input  logic                     sig_ovf,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic [WIDTH-1:0]         res_data,
    output logic                     res_ovf,
    output logic                     busy
);

    localparam logic [ID_W:0]   c_NUM_REQ = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

    generate
        if (NUM_REQ < 2 || (2 ** ID_W) < NUM_REQ || FRAC_BITS >= WIDTH) begin : g_bad_params
            $error("sigmoid_gate_scheduler: inconsistent NUM_REQ/ID_W/FRAC_BITS");
        end
    endgenerate

    logic                 r_s1_valid;
    logic [ID_W-1:0]      r_s1_id;
    logic [WIDTH-1:0]     r_s1_data;
    logic                 r_s2_valid;
    logic [ID_W-1:0]      r_s2_id;
    logic [WIDTH-1:0]     r_s2_data;
    logic                 r_s2_ovf;
    logic [ID_W-1:0]      r_rr_ptr;

    logic [NUM_REQ-1:0]   w_req_rot;
    logic                 w_found;
    logic [ID_W-1:0]      w_offset;
    logic [ID_W:0]        w_sum;
    logic [ID_W-1:0]      w_grant;
    logic [ID_W-1:0]      w_rr_next;
    logic [WIDTH-1:0]     w_grant_data;
    logic [NUM_REQ-1:0]   w_req_ready;
    logic                 w_s1_adv;
    logic                 w_s2_adv;
    logic                 w_accept;

    // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
    assign w_req_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);

    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_found  = 1'b1;
                w_offset = ID_W'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_grant   = (w_sum >= c_NUM_REQ) ? ID_W'(w_sum - c_NUM_REQ) : w_sum[ID_W-1:0];
    assign w_rr_next = (w_grant == c_LAST_ID) ? '0 : w_grant + 1'b1;

    assign w_s2_adv  = !r_s2_valid || res_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_accept  = w_found && w_s1_adv && !rst;

    always_comb begin
        w_req_ready  = '0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_req_ready[i] = w_accept;
                w_grant_data   = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_data  <= '0;
            r_s2_ovf   <= 1'b0;
            r_rr_ptr   <= '0;
        end else begin
            // s1 data holds through bubbles so the sigmoid input does not toggle.
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_id   <= w_grant;
                    r_s1_data <= w_grant_data;
                end
            end
            if (w_accept) begin
                r_rr_ptr <= w_rr_next;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                r_s2_id    <= r_s1_id;
                r_s2_data  <= sig_out;
                r_s2_ovf   <= sig_ovf;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign sig_in    = r_s1_data;
    assign res_valid = r_s2_valid;
    assign res_id    = r_s2_id;
    assign res_data  = r_s2_data;
    assign res_ovf   = r_s2_ovf;
    assign busy      = r_s1_valid || r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_gate_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sigmoid_gate_scheduler                                        |
// | Brief   : Scoreboard bench for sigmoid_gate_scheduler with a hard-sigmoid  |
// |           model standing in for the shared sigmoid unit.                   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sigmoid_gate_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic [15:0] sig_in;
    logic [15:0] sig_out;
    logic        sig_ovf;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        busy;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   grant_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pop    = 0;

    sigmoid_gate_scheduler #(
        .WIDTH(16), .FRAC_BITS(8), .NUM_REQ(3), .ID_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .sig_in(sig_in), .sig_out(sig_out), .sig_ovf(sig_ovf),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data), .res_ovf(res_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Hard sigmoid in S7.8: y = clamp(x/4 + 0.5, 0, 1), overflow flags clamping.
    function automatic logic [16:0] sig_model(input logic [15:0] x);
        int t;
        t = ($signed(x) >>> 2) + 128;
        if (t > 256) return {1'b1, 16'h0100};
        if (t < 0)   return {1'b1, 16'h0000};
        return {1'b0, t[15:0]};
    endfunction

    always_comb {sig_ovf, sig_out} = sig_model(sig_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_data(input int i, input logic [15:0] v);
        req_data[i*16 +: 16] = v;
    endtask

    // Accept tracker: pushes the expected result and checks the grant order.
    logic [16:0] push_w;
    int          push_g;
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    push_w = sig_model(req_data[i*16 +: 16]);
                    sb_q.push_back('{id: 2'(i), data: push_w[15:0], ovf: push_w[16]});
                    if (grant_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL grant_extra: got grant %0d expected none", i);
                    end else begin
                        push_g = grant_q.pop_front();
                        chk("grant_order", 32'(i), 32'(push_g));
                    end
                end
            end
        end
    end

    // Result monitor: compares each transferred result and checks hold under backpressure.
    exp_t mon_e;
    exp_t held;
    logic held_v = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                n_pop++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL res_unexpected: got id=%0d data=%0h expected no result", res_id, res_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("res_id",   32'(res_id),   32'(mon_e.id));
                    chk("res_data", 32'(res_data), 32'(mon_e.data));
                    chk("res_ovf",  32'(res_ovf),  32'(mon_e.ovf));
                end
            end
            if (res_valid && !res_ready) begin
                if (held_v) chk("res_hold", 32'({res_id, res_data, res_ovf}), 32'(held));
                held   = '{id: res_id, data: res_data, ovf: res_ovf};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] t5_data [5];
    int          snap;
    int          idx;
    logic        acc;

    initial begin
        // T1: reset with all requesters valid
        rst       = 1'b1;
        req_valid = 3'b111;
        req_data  = '0;
        res_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t1_ready_in_reset", 32'(req_ready), 32'd0);
        end
        tick(1);
        rst       = 1'b0;
        req_valid = 3'b000;
        chk("t1_res_valid", 32'(res_valid), 32'd0);
        chk("t1_busy",      32'(busy),      32'd0);

        // T2: single request, sigmoid(0) = 0.5
        set_data(0, 16'h0000);
        req_valid = 3'b001;
        grant_q.push_back(0);
        @(negedge clk);
        chk("t2_ready", 32'(req_ready), 32'b001);
        tick(1);
        req_valid = 3'b000;
        tick(1);
        chk("t2_res_valid", 32'(res_valid), 32'd1);
        chk("t2_res_id",    32'(res_id),    32'd0);
        chk("t2_res_data",  32'(res_data),  32'h0080);
        tick(3);

        // Move rr_ptr back to 0 via a lone req2 grant
        set_data(2, 16'h0100);
        req_valid = 3'b100;
        grant_q.push_back(2);
        tick(1);
        req_valid = 3'b000;
        tick(3);

        // T3: round robin with all three valid
        set_data(0, 16'hFF00);
        set_data(1, 16'h0200);
        set_data(2, 16'hFC00);
        foreach (grant_q[i]) ;
        for (int k = 0; k < 6; k++) grant_q.push_back(k % 3);
        snap      = n_pop;
        req_valid = 3'b111;
        tick(6);
        req_valid = 3'b000;
        tick(2);
        chk("t3_throughput", 32'(n_pop - snap), 32'd6);
        tick(2);

        // T4: rr_ptr=2, only req0 valid, saturating operand
        set_data(1, 16'h0080);
        req_valid = 3'b010;
        grant_q.push_back(1);
        tick(1);
        set_data(0, 16'h0800);
        req_valid = 3'b001;
        grant_q.push_back(0);
        @(negedge clk);
        chk("t4_wrap_grant", 32'(req_ready), 32'b001);
        tick(1);
        req_valid = 3'b111;
        grant_q.push_back(1);
        @(negedge clk);
        chk("t4_rr_ptr_is_1", 32'(req_ready), 32'b010);
        tick(1);
        req_valid = 3'b000;
        chk("t4_res_id",   32'(res_id),   32'd0);
        chk("t4_res_data", 32'(res_data), 32'h0100);
        chk("t4_res_ovf",  32'(res_ovf),  32'd1);
        tick(3);

        // T5: stream from req1 with 4 cycles of backpressure
        t5_data[0] = 16'h0000;
        t5_data[1] = 16'h0040;
        t5_data[2] = 16'h0100;
        t5_data[3] = 16'hFF80;
        t5_data[4] = 16'h7FFF;
        repeat (5) grant_q.push_back(1);
        snap = n_pop;
        idx  = 0;
        for (int c = 0; c < 12 && idx < 5; c++) begin
            res_ready = (c >= 1 && c <= 4) ? 1'b0 : 1'b1;
            req_valid = 3'b010;
            set_data(1, t5_data[idx]);
            @(negedge clk);
            if (c >= 2 && c <= 4) chk("t5_ready_low_full", 32'(req_ready), 32'd0);
            acc = req_ready[1];
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("t5_all_accepted", 32'(idx), 32'd5);
        req_valid = 3'b000;
        res_ready = 1'b1;
        tick(3);
        chk("t5_no_loss", 32'(n_pop - snap), 32'd5);

        // T6: reset with both stages full
        set_data(0, 16'h0000);
        set_data(1, 16'h0100);
        set_data(2, 16'h0200);
        res_ready = 1'b0;
        req_valid = 3'b111;
        grant_q.push_back(2);
        grant_q.push_back(0);
        tick(2);
        chk("t6_full_before_rst", 32'({res_valid, busy}), 32'b11);
        rst       = 1'b1;
        req_valid = 3'b000;
        tick(1);
        rst       = 1'b0;
        res_ready = 1'b1;
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        chk("t6_busy",      32'(busy),      32'd0);
        tick(3);
        req_valid = 3'b111;
        grant_q.push_back(0);
        @(negedge clk);
        chk("t6_rr_ptr_reset", 32'(req_ready), 32'b001);
        tick(1);
        req_valid = 3'b000;
        tick(4);

        chk("sb_empty",    32'(sb_q.size()),    32'd0);
        chk("grant_empty", 32'(grant_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
